// File: rtl/axicb_pkg.sv
// Shared types for the axicb stream blocks.
// Holds only the reader buffer state encoding.
package axicb_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axicb_fifo_reader.sv
// Turns a zero-latency FIFO pull/empty read port into a registered valid/ready
// stream, using a main register plus one skid register so that pull never waits on o_ready.
module axicb_fifo_reader
    import axicb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pull,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            level,
    output logic [1:0]            state_dbg
);

    // Handshakes: a FIFO beat is consumed when fifo_pull & ~fifo_empty; an output
    // beat transfers when o_valid & o_ready, and o_data holds while o_valid & ~o_ready.

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  rd;
    logic                  fire;
    logic                  load_main;
    logic                  load_skid;
    logic                  main_from_skid;

    assign rd     = fifo_pull & ~fifo_empty;
    assign fire   = o_valid & o_ready;
    assign o_data = main_q;

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (rd) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (rd && fire) begin
                    load_main = 1'b1;
                end else if (rd) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (fire) begin
                    state_d        = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A transfer in the flush/reset cycle still completes; only buffered beats are lost.
        if (srst || flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        fifo_pull = (state_q != ST_TWO) & ~flush & ~srst;
        o_valid   = (state_q != ST_EMPTY);
        level     = state_q;
        state_dbg = state_q;
    end

    // Data registers carry no reset; o_data is meaningless while o_valid is low.
    always_ff @(posedge aclk) begin
        if (load_main) begin
            main_q <= fifo_data;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= fifo_data;
        end
    end

endmodule

// File: tb/tb_axicb_fifo_reader.sv
// Directed bench for axicb_fifo_reader with a queue-backed FIFO model and an
// expected-beat scoreboard checked on every output transfer.
module tb_axicb_fifo_reader;

    localparam int W = 8;

    logic         aclk;
    logic         srst;
    logic         flush;
    logic [W-1:0] fifo_data;
    logic         fifo_empty;
    logic         fifo_pull;
    logic         o_valid;
    logic         o_ready;
    logic [W-1:0] o_data;
    logic [1:0]   level;
    logic [1:0]   state_dbg;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic         hold_empty;
    int           checks;
    int           errors;

    axicb_fifo_reader #(.DATA_WIDTH(W)) dut (
        .aclk       (aclk),
        .srst       (srst),
        .flush      (flush),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pull  (fifo_pull),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .level      (level),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (src_q.size() == 0) || hold_empty;
        fifo_data  = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        src_q.push_back(v);
        exp_q.push_back(v);
        drive_fifo();
    endtask

    // One clock: sample handshakes before the edge, update FIFO model and scoreboard after it.
    task automatic cycle();
        logic         was_rd;
        logic         was_fire;
        logic         was_stall;
        logic [W-1:0] d;
        logic [W-1:0] e;
        #1;
        was_rd    = fifo_pull & ~fifo_empty;
        was_fire  = o_valid & o_ready;
        was_stall = o_valid & ~o_ready & ~flush & ~srst;
        d         = o_data;
        @(posedge aclk);
        #1;
        if (was_rd) void'(src_q.pop_front());
        if (was_fire) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", {24'd0, d}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_order", {24'd0, d}, {24'd0, e});
            end
        end
        if (was_stall) begin
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_data", {24'd0, o_data}, {24'd0, d});
        end
        chk("level_max", {31'd0, (level <= 2'd2)}, 32'd1);
        drive_fifo();
    endtask

    initial begin
        int budget;
        checks     = 0;
        errors     = 0;
        srst       = 1'b1;
        flush      = 1'b0;
        o_ready    = 1'b0;
        hold_empty = 1'b0;
        drive_fifo();

        // reset state
        #1;
        chk("rst_pull", {31'd0, fifo_pull}, 32'd0);
        cycle();
        cycle();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_level", {30'd0, level}, 32'd0);
        srst = 1'b0;

        // full-rate stream of 0x01..0x10
        o_ready = 1'b1;
        for (int i = 1; i <= 16; i++) load(W'(i));
        #1;
        chk("stream_first_pull", {31'd0, fifo_pull}, 32'd1);
        chk("stream_valid_before", {31'd0, o_valid}, 32'd0);
        cycle();
        for (int i = 1; i <= 16; i++) begin
            chk("stream_valid", {31'd0, o_valid}, 32'd1);
            chk("stream_data", {24'd0, o_data}, i);
            cycle();
        end
        chk("stream_done_valid", {31'd0, o_valid}, 32'd0);
        chk("stream_done_level", {30'd0, level}, 32'd0);

        // backpressure with four queued beats
        o_ready = 1'b0;
        for (int i = 1; i <= 4; i++) load(W'(i));
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("bp_level", {30'd0, level}, 32'd2);
            chk("bp_pull", {31'd0, fifo_pull}, 32'd0);
            chk("bp_data", {24'd0, o_data}, 32'h01);
            cycle();
        end
        o_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("bp_drain_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_drain_data", {24'd0, o_data}, i);
            cycle();
        end
        chk("bp_done_valid", {31'd0, o_valid}, 32'd0);

        // source runs dry while holding one beat
        o_ready = 1'b0;
        load(8'h55);
        cycle();
        chk("dry_level1", {30'd0, level}, 32'd1);
        chk("dry_src_empty", {31'd0, fifo_empty}, 32'd1);
        o_ready = 1'b1;
        cycle();
        chk("dry_valid", {31'd0, o_valid}, 32'd0);
        chk("dry_level0", {30'd0, level}, 32'd0);

        // flush with 0xA1, 0xA2 buffered and 0xB0 waiting
        o_ready = 1'b0;
        load(8'hA1);
        load(8'hA2);
        load(8'hB0);
        cycle();
        cycle();
        chk("fl_level2", {30'd0, level}, 32'd2);
        chk("fl_data", {24'd0, o_data}, 32'hA1);
        flush = 1'b1;
        #1;
        chk("fl_pull", {31'd0, fifo_pull}, 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        cycle();
        flush = 1'b0;
        chk("fl_valid", {31'd0, o_valid}, 32'd0);
        chk("fl_level0", {30'd0, level}, 32'd0);
        o_ready = 1'b1;
        cycle();
        chk("fl_next_valid", {31'd0, o_valid}, 32'd1);
        chk("fl_next_data", {24'd0, o_data}, 32'hB0);
        cycle();

        // reset during a full-rate stream of 0x20..0x2F
        for (int i = 0; i < 16; i++) load(W'(8'h20 + i));
        cycle();
        cycle();
        cycle();
        chk("srst_pre_data", {24'd0, o_data}, 32'h22);
        srst = 1'b1;
        #1;
        chk("srst_pull", {31'd0, fifo_pull}, 32'd0);
        cycle();
        chk("srst_valid", {31'd0, o_valid}, 32'd0);
        chk("srst_level", {30'd0, level}, 32'd0);
        srst = 1'b0;
        cycle();
        chk("srst_resume_valid", {31'd0, o_valid}, 32'd1);
        chk("srst_resume_data", {24'd0, o_data}, 32'h23);
        budget = 0;
        while ((exp_q.size() != 0) && (budget < 100)) begin
            cycle();
            budget++;
        end
        chk("srst_drain_timeout", {31'd0, (exp_q.size() == 0)}, 32'd1);

        // 1000 beats under random backpressure and source gaps
        for (int i = 0; i < 1000; i++) load(W'($urandom_range(0, 255)));
        budget = 0;
        while ((exp_q.size() != 0) && (budget < 20000)) begin
            o_ready    = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            drive_fifo();
            cycle();
            budget++;
        end
        hold_empty = 1'b0;
        drive_fifo();
        chk("rand_drain_timeout", {31'd0, (exp_q.size() == 0)}, 32'd1);
        chk("rand_src_empty", {31'd0, (src_q.size() == 0)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axicb_fifo_reader.md
AXICB_FIFO_READER -- requirements
Module: axicb_fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the FIFO data and output data.
REQ-002 aclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 srst  input  1  SHALL be the synchronous reset, active-high; there is no asynchronous reset.
REQ-004 flush  input  1  SHALL synchronously discard all buffered beats, same effect as srst.
REQ-005 fifo_data  input  DATA_WIDTH  SHALL be the FIFO read data, valid in the same cycle as ~fifo_empty (zero-latency RAM read).
REQ-006 fifo_empty  input  1  SHALL be the FIFO empty flag.
REQ-007 fifo_pull  output  1  SHALL be the FIFO pull strobe; a beat is read when fifo_pull & ~fifo_empty.
REQ-008 o_valid  output  1  SHALL flag a valid output beat.
REQ-009 o_ready  input  1  SHALL be the downstream acceptance; a beat transfers when o_valid & o_ready.
REQ-010 o_data  output  DATA_WIDTH  SHALL be the output beat, driven directly from a register.
REQ-011 level  output  2  SHALL report buffered beats (0, 1 or 2).

Function
REQ-012 The block SHALL convert the FIFO pull/empty read port into a valid/ready stream with a 2-entry register buffer (main, skid).
REQ-013 States SHALL be EMPTY (0 beats), ONE (main valid) and TWO (main and skid valid).
REQ-014 fifo_pull SHALL be (state != TWO) & ~flush & ~srst and SHALL NOT depend combinationally on o_ready.
REQ-015 rd SHALL be defined as fifo_pull & ~fifo_empty and fire as o_valid & o_ready.
REQ-016 EMPTY: rd -> ONE with main <= fifo_data; otherwise stay.
REQ-017 ONE: rd & fire -> ONE, main <= fifo_data; rd & ~fire -> TWO, skid <= fifo_data; ~rd & fire -> EMPTY; else hold.
REQ-018 TWO: fire -> ONE, main <= skid; ~fire -> hold all registers.
REQ-019 o_valid SHALL be (state != EMPTY), o_data SHALL be main, and level SHALL be 0/1/2 for EMPTY/ONE/TWO.
REQ-020 o_data SHALL remain stable while o_valid & ~o_ready (AXI stability rule).
REQ-021 With fifo_empty=0 and o_ready=1 continuously, throughput SHALL be one beat per cycle after the first beat.
REQ-022 Latency from the first rd to o_valid SHALL be one cycle.
REQ-023 Beat order SHALL be preserved; no beat SHALL be duplicated or dropped except by flush or srst.
REQ-024 fifo_empty=1 SHALL cause no read and no state change other than fire-driven transitions.
REQ-025 flush or srst in any state SHALL force EMPTY next cycle; a fire in that cycle is still a valid transfer, but no FIFO beat is read.

Reset
REQ-026 On srst: state=EMPTY, o_valid=0, level=0, fifo_pull=0 during the reset cycle.
REQ-027 main and skid data registers SHALL NOT require reset; o_data is don't-care while o_valid=0.
REQ-028 srst asserted mid-burst SHALL drop the buffered beats; the FIFO itself is flushed separately by its owner.

Structure
REQ-029 State encoding (EMPTY/ONE/TWO) SHALL be a typedef in the shared axicb package, with no other shared constants.
REQ-030 The block SHALL be a single module with no sub-modules, paired externally with axicb_scfifo in store mode (PASS_THRU=0).

Verification
REQ-031 Stream: FIFO preloaded with 0x01..0x10 and o_ready=1 -> o_data 0x01..0x10 on 16 consecutive cycles, first o_valid one cycle after the first pull.
REQ-032 Backpressure: o_ready=0 from the start with 4 beats queued -> level=2, fifo_pull=0, o_data=0x01 stable; o_ready=1 -> 0x01..0x04 delivered in order without a gap.
REQ-033 Random: o_ready toggled at 50% for 1000 beats -> scoreboard exact order match, level never >2, o_data never changes while o_valid & ~o_ready.
REQ-034 Empty source: fifo_empty=1 with level=1 and o_ready=1 -> o_valid drops next cycle, level=0, no pull.
REQ-035 Flush: level=2 holding 0xA1,0xA2, flush pulsed -> next cycle o_valid=0, level=0; the next FIFO beat 0xB0 appears as the first output.
REQ-036 Reset: srst asserted during a full-rate stream -> fifo_pull=0 that cycle, o_valid=0 next cycle; after release, streaming resumes from the next FIFO beat.
